// File: rtl/if_pkg.sv
// Shared constants and FSM encoding for the instruction-fetch stage.
package if_pkg;

   localparam int unsigned PC_W = 32;

   localparam logic [PC_W-1:0] IF_NOP_INST = 32'h0000_0000;
   localparam logic [PC_W-1:0] PC_STEP     = PC_W'(4);

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      DROP  = 2'd1,
      HOLD  = 2'd2
   } if_state_e;

endpackage

// File: rtl/if_fetch_buf.sv
// One-entry holding buffer for an instruction whose fetch completed while ID was stalled.
module if_fetch_buf
   import if_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            capture,
   input  logic            clear,
   input  logic [PC_W-1:0] cap_pc,
   input  logic [PC_W-1:0] cap_inst,
   output logic            valid,
   output logic [PC_W-1:0] pc,
   output logic [PC_W-1:0] inst
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= 1'b0;
         pc    <= '0;
         inst  <= IF_NOP_INST;
      end else if (clear) begin
         valid <= 1'b0;
      end else if (capture) begin
         valid <= 1'b1;
         pc    <= cap_pc;
         inst  <= cap_inst;
      end
   end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC sequencing, imem handshake, redirect flush and stall hold.
// Define IF_FETCH_BUF_EN to buffer one instruction fetched during a stall and release it bubble-free.
module if_stage
   import if_pkg::*;
#(
   parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000,
   parameter logic [PC_W-1:0] NOP_INST = IF_NOP_INST
) (
   input  logic            Clk,
   input  logic            Rst_n,
   input  logic            Stall,
   input  logic            Branch_Taken,
   input  logic [PC_W-1:0] Branch_Target,
   input  logic            Jump,
   input  logic [PC_W-1:0] Jump_Target,
   output logic            Imem_Req,
   output logic [PC_W-1:0] Imem_Addr,
   input  logic            Imem_Ready,
   input  logic [PC_W-1:0] Imem_Rdata,
   output logic [PC_W-1:0] O_PC,
   output logic [PC_W-1:0] O_PC4,
   output logic [PC_W-1:0] O_Inst,
   output logic            O_Valid
);

   if_state_e       state_q, state_d;
   logic [PC_W-1:0] addr_d, tgt_q, tgt_d;
   logic [PC_W-1:0] pc_d, pc4_d, inst_d;
   logic            valid_d, req_d;
   logic            hs, redirect;
   logic [PC_W-1:0] target;
   logic            buf_cap, buf_clr, buf_valid;
   logic [PC_W-1:0] buf_pc, buf_inst;

`ifdef IF_FETCH_BUF_EN
   localparam bit BUF_EN = 1'b1;

   if_fetch_buf u_fetch_buf (
      .clk      (Clk),
      .rst_n    (Rst_n),
      .capture  (buf_cap),
      .clear    (buf_clr),
      .cap_pc   (Imem_Addr),
      .cap_inst (Imem_Rdata),
      .valid    (buf_valid),
      .pc       (buf_pc),
      .inst     (buf_inst)
   );
`else
   localparam bit BUF_EN = 1'b0;

   logic unused_buf;
   assign buf_valid  = 1'b0;
   assign buf_pc     = '0;
   assign buf_inst   = '0;
   assign unused_buf = buf_cap ^ buf_clr;
`endif

   assign hs       = Imem_Req & Imem_Ready;
   assign redirect = Branch_Taken | Jump;
   assign target   = Branch_Taken ? Branch_Target : Jump_Target;

   // Next-state and output decode; redirect outranks stall and any pending data.
   always_comb begin
      state_d = state_q;
      addr_d  = Imem_Addr;
      tgt_d   = tgt_q;
      pc_d    = O_PC;
      pc4_d   = O_PC4;
      inst_d  = O_Inst;
      valid_d = O_Valid;
      buf_cap = 1'b0;
      buf_clr = 1'b0;

      if (redirect) begin
         valid_d = 1'b0;
         inst_d  = NOP_INST;
         buf_clr = 1'b1;
         if (hs || !Imem_Req) begin
            addr_d  = target;
            state_d = FETCH;
         end else begin
            tgt_d   = target;
            state_d = DROP;
         end
      end else begin
         case (state_q)
            DROP: begin
               if (!Stall) begin
                  valid_d = 1'b0;
                  inst_d  = NOP_INST;
               end
               if (hs) begin
                  addr_d  = tgt_q;
                  state_d = FETCH;
               end
            end
            HOLD: begin
               if (!Stall) begin
                  state_d = FETCH;
                  buf_clr = 1'b1;
                  valid_d = buf_valid;
                  if (buf_valid) begin
                     pc_d   = buf_pc;
                     pc4_d  = buf_pc + PC_STEP;
                     inst_d = buf_inst;
                  end else begin
                     inst_d = NOP_INST;
                  end
               end
            end
            default: begin
               if (Stall) begin
                  // Without the buffer the returned word is dropped and its address re-fetched later.
                  if (hs) begin
                     state_d = HOLD;
                     if (BUF_EN) begin
                        buf_cap = 1'b1;
                        addr_d  = Imem_Addr + PC_STEP;
                     end
                  end
               end else if (hs) begin
                  pc_d    = Imem_Addr;
                  pc4_d   = Imem_Addr + PC_STEP;
                  inst_d  = Imem_Rdata;
                  valid_d = 1'b1;
                  addr_d  = Imem_Addr + PC_STEP;
               end else begin
                  valid_d = 1'b0;
                  inst_d  = NOP_INST;
               end
            end
         endcase
      end

      req_d = (state_d != HOLD);
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q   <= FETCH;
         Imem_Req  <= 1'b0;
         Imem_Addr <= RESET_PC;
         tgt_q     <= '0;
         O_PC      <= '0;
         O_PC4     <= '0;
         O_Inst    <= NOP_INST;
         O_Valid   <= 1'b0;
      end else begin
         state_q   <= state_d;
         Imem_Req  <= req_d;
         Imem_Addr <= addr_d;
         tgt_q     <= tgt_d;
         O_PC      <= pc_d;
         O_PC4     <= pc4_d;
         O_Inst    <= inst_d;
         O_Valid   <= valid_d;
      end
   end

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: directed scenarios followed by random stall/redirect/wait traffic.
module tb_if_stage;

   localparam logic [31:0] KEY         = 32'hA5A5_0000;
   localparam logic [31:0] NOP         = 32'h0000_0000;
   localparam logic [31:0] RST_PC      = 32'h0000_0000;
   localparam int          RAND_CYCLES = 4000;

   logic        Clk = 1'b0;
   logic        Rst_n, Stall, Branch_Taken, Jump, Imem_Ready;
   logic [31:0] Branch_Target, Jump_Target, Imem_Rdata;
   logic        Imem_Req, O_Valid;
   logic [31:0] Imem_Addr, O_PC, O_PC4, O_Inst;

   int          errors   = 0;
   int          checks   = 0;
   int          consumed = 0;
   logic [31:0] tgt_q[$];

   if_stage dut (
      .Clk           (Clk),
      .Rst_n         (Rst_n),
      .Stall         (Stall),
      .Branch_Taken  (Branch_Taken),
      .Branch_Target (Branch_Target),
      .Jump          (Jump),
      .Jump_Target   (Jump_Target),
      .Imem_Req      (Imem_Req),
      .Imem_Addr     (Imem_Addr),
      .Imem_Ready    (Imem_Ready),
      .Imem_Rdata    (Imem_Rdata),
      .O_PC          (O_PC),
      .O_PC4         (O_PC4),
      .O_Inst        (O_Inst),
      .O_Valid       (O_Valid)
   );

   always #5 Clk = ~Clk;

   // Memory returns an address-tagged word only on a handshake, garbage otherwise.
   assign Imem_Rdata = (Imem_Req && Imem_Ready) ? (Imem_Addr ^ KEY) : 32'hDEAD_BEEF;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   // Expected next program-order PC after a redirect follows the branch-over-jump rule.
   task automatic set_redirect(input logic bt, input logic [31:0] btgt,
                               input logic jv, input logic [31:0] jtgt);
      Branch_Taken  = bt;
      Branch_Target = btgt;
      Jump          = jv;
      Jump_Target   = jtgt;
      if (bt || jv) tgt_q.push_back(bt ? btgt : jtgt);
   endtask

   // Monitor: every instruction ID consumes must be the next one in program order.
   initial begin : monitor
      logic [31:0] exp_pc, prev_addr;
      logic        prev_req, prev_rdy, have_prev;
      exp_pc    = RST_PC;
      prev_addr = '0;
      prev_req  = 1'b0;
      prev_rdy  = 1'b0;
      have_prev = 1'b0;
      forever begin
         @(negedge Clk);
         if (!Rst_n) begin
            exp_pc    = RST_PC;
            have_prev = 1'b0;
            tgt_q.delete();
         end else begin
            if (!O_Valid) check("nop_when_invalid", O_Inst, NOP);
            if (have_prev && prev_req && !prev_rdy) begin
               check("req_held_while_waiting", 32'(Imem_Req), 32'd1);
               check("addr_held_while_waiting", Imem_Addr, prev_addr);
            end
            if (O_Valid && !Stall) begin
               consumed++;
               check("stream_pc", O_PC, exp_pc);
               check("stream_pc4", O_PC4, exp_pc + 32'd4);
               check("stream_inst", O_Inst, exp_pc ^ KEY);
               exp_pc = exp_pc + 32'd4;
            end
            if (Branch_Taken || Jump) begin
               if (tgt_q.size() == 0) check("redirect_queue_underflow", 32'd1, 32'd0);
               else exp_pc = tgt_q.pop_front();
            end
            prev_req  = Imem_Req;
            prev_rdy  = Imem_Ready;
            prev_addr = Imem_Addr;
            have_prev = 1'b1;
         end
      end
   end

   initial begin : stimulus
      Rst_n      = 1'b0;
      Stall      = 1'b0;
      Imem_Ready = 1'b1;
      set_redirect(1'b0, '0, 1'b0, '0);
      repeat (3) tick();
      check("rst_req", 32'(Imem_Req), 32'd0);
      check("rst_addr", Imem_Addr, RST_PC);
      check("rst_valid", 32'(O_Valid), 32'd0);
      check("rst_inst", O_Inst, NOP);
      check("rst_pc", O_PC, 32'd0);
      check("rst_pc4", O_PC4, 32'd0);

      // Zero-wait streaming from reset.
      Rst_n = 1'b1;
      tick();
      check("req_after_rst", 32'(Imem_Req), 32'd1);
      check("first_addr", Imem_Addr, 32'h0);
      tick();
      check("s0_pc", O_PC, 32'h0);
      check("s0_pc4", O_PC4, 32'h4);
      check("s0_valid", 32'(O_Valid), 32'd1);
      check("s0_inst", O_Inst, KEY);
      check("s0_addr", Imem_Addr, 32'h4);
      tick();
      check("s1_pc", O_PC, 32'h4);
      check("s1_pc4", O_PC4, 32'h8);
      check("s1_valid", 32'(O_Valid), 32'd1);
      check("s1_addr", Imem_Addr, 32'h8);

      // Three wait states at 0x8.
      Imem_Ready = 1'b0;
      repeat (3) begin
         tick();
         check("wait_addr", Imem_Addr, 32'h8);
         check("wait_req", 32'(Imem_Req), 32'd1);
         check("wait_valid", 32'(O_Valid), 32'd0);
      end
      Imem_Ready = 1'b1;
      tick();
      check("after_wait_pc", O_PC, 32'h8);
      check("after_wait_valid", 32'(O_Valid), 32'd1);

      // Branch while the request at 0x10 is still waiting.
      tick();
      Imem_Ready = 1'b0;
      tick();
      check("br_wait_addr", Imem_Addr, 32'h10);
      set_redirect(1'b1, 32'h40, 1'b0, '0);
      tick();
      set_redirect(1'b0, '0, 1'b0, '0);
      check("br_flush_valid", 32'(O_Valid), 32'd0);
      check("br_pending_addr", Imem_Addr, 32'h10);
      tick();
      Imem_Ready = 1'b1;
      tick();
      check("br_next_addr", Imem_Addr, 32'h40);
      check("br_drop_valid", 32'(O_Valid), 32'd0);
      tick();
      check("br_target_pc", O_PC, 32'h40);
      check("br_target_valid", 32'(O_Valid), 32'd1);

      // Branch and jump together: branch wins.
      set_redirect(1'b1, 32'h80, 1'b1, 32'h100);
      tick();
      set_redirect(1'b1 & 1'b0, '0, 1'b0, '0);
      check("prio_addr", Imem_Addr, 32'h80);
      check("prio_valid", 32'(O_Valid), 32'd0);
      tick();
      check("prio_pc", O_PC, 32'h80);
      check("prio_valid_back", 32'(O_Valid), 32'd1);

      // Two-cycle stall with O_PC = 0x4.
      set_redirect(1'b0, '0, 1'b1, 32'h0);
      tick();
      set_redirect(1'b0, '0, 1'b0, '0);
      tick();
      tick();
      check("stall_pre_pc", O_PC, 32'h4);
      Stall = 1'b1;
      repeat (2) begin
         tick();
         check("stall_hold_pc", O_PC, 32'h4);
         check("stall_hold_valid", 32'(O_Valid), 32'd1);
      end
      Stall = 1'b0;
      tick();
`ifdef IF_FETCH_BUF_EN
      check("release_pc", O_PC, 32'h8);
      check("release_valid", 32'(O_Valid), 32'd1);
      tick();
      check("release_next_pc", O_PC, 32'hC);
`else
      check("release_bubble", 32'(O_Valid), 32'd0);
      tick();
      check("release_pc", O_PC, 32'h8);
      check("release_valid", 32'(O_Valid), 32'd1);
`endif

      // Asynchronous reset during a wait at 0x20.
      set_redirect(1'b0, '0, 1'b1, 32'h20);
      tick();
      set_redirect(1'b0, '0, 1'b0, '0);
      check("pre_rst_addr", Imem_Addr, 32'h20);
      Imem_Ready = 1'b0;
      tick();
      check("pre_rst_req", 32'(Imem_Req), 32'd1);
      #2 Rst_n = 1'b0;
      #1;
      check("async_rst_req", 32'(Imem_Req), 32'd0);
      check("async_rst_addr", Imem_Addr, RST_PC);
      check("async_rst_valid", 32'(O_Valid), 32'd0);
      check("async_rst_pc", O_PC, 32'd0);
      check("async_rst_inst", O_Inst, NOP);
      tick();
      tick();
      Imem_Ready = 1'b1;
      Rst_n      = 1'b1;
      tick();
      check("rerst_req", 32'(Imem_Req), 32'd1);
      check("rerst_addr", Imem_Addr, RST_PC);
      tick();
      check("rerst_pc", O_PC, RST_PC);
      check("rerst_valid", 32'(O_Valid), 32'd1);

      // Random traffic, including simultaneous branch/jump and unaligned targets.
      for (int i = 0; i < RAND_CYCLES; i++) begin
         int unsigned r;
         r          = $urandom_range(0, 99);
         Stall      = ($urandom_range(0, 99) < 15);
         Imem_Ready = ($urandom_range(0, 99) < 70);
         set_redirect(r < 5, $urandom_range(0, 32'h0000_FFFF),
                      (r >= 3) && (r < 9), $urandom_range(0, 32'h0000_FFFF));
         tick();
      end
      set_redirect(1'b0, '0, 1'b0, '0);
      Stall      = 1'b0;
      Imem_Ready = 1'b1;
      repeat (20) tick();

      check("progress", 32'(consumed > 500), 32'd1);
      check("redirects_all_seen", 32'(tgt_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: fetch address after reset.
REQ-002 Parameter NOP_INST, default 32'h0000_0000: instruction driven while O_Valid is low.
REQ-003 Clk  input  1: single clock; all state updates on posedge Clk.
REQ-004 Rst_n  input  1: asynchronous, active-low reset.
REQ-005 Stall  input  1: hazard hold from ID; when high, O_* and PC are held.
REQ-006 Branch_Taken  input  1: branch redirect request.
REQ-007 Branch_Target  input  32: branch redirect address.
REQ-008 Jump  input  1: jump redirect request.
REQ-009 Jump_Target  input  32: jump redirect address.
REQ-010 Imem_Req  output  1: instruction-memory read request.
REQ-011 Imem_Addr  output  32: word address of the request.
REQ-012 Imem_Ready  input  1: memory accepts the request and returns data this cycle.
REQ-013 Imem_Rdata  input  32: instruction word, valid when Imem_Req and Imem_Ready are both high.
REQ-014 O_PC, O_PC4, O_Inst  output  32 each: fetched PC, PC+4 and instruction, feeding the IF/ID register inputs I_PC, I_PC4 and I_Inst.
REQ-015 O_Valid  output  1: O_* hold a live instruction; when low, O_Inst equals NOP_INST.

Function
REQ-016 A handshake SHALL complete at a posedge where Imem_Req=1 and Imem_Ready=1.
REQ-017 Imem_Addr SHALL stay stable while Imem_Req=1 and Imem_Ready=0.
REQ-018 FSM states: FETCH (request outstanding), DROP (request outstanding, data to be discarded), HOLD (Stall high, no request).
REQ-019 FETCH, handshake, no redirect, no Stall: O_PC<=Imem_Addr, O_PC4<=Imem_Addr+4 (mod 2^32), O_Inst<=Imem_Rdata, O_Valid<=1; next Imem_Addr=Imem_Addr+4.
REQ-020 With zero-wait memory (Imem_Ready always 1), throughput SHALL be one instruction per cycle with one-cycle latency from handshake to O_*.
REQ-021 FETCH, no handshake: O_Valid<=0 and O_Inst<=NOP_INST; the FSM stays in FETCH.
REQ-022 Redirect target: Branch_Target if Branch_Taken; else Jump_Target if Jump; Branch_Taken has priority.
REQ-023 Redirect, any state: O_Valid<=0 and O_Inst<=NOP_INST next cycle (flush).
REQ-024 Redirect with handshake this cycle, or in HOLD: next Imem_Addr=target; state FETCH.
REQ-025 Redirect with request pending (no handshake): target latched; state DROP; returned data discarded; then FETCH at target.
REQ-026 A later redirect during DROP SHALL overwrite the latched target.
REQ-027 Redirect SHALL take priority over Stall.
REQ-028 Stall high, no redirect: O_* and O_Valid held; PC not advanced; a completing handshake is handled per REQ-038/REQ-039.
REQ-029 Target addresses SHALL be used as given; bits [1:0] are not checked.

Reset
REQ-030 Rst_n low SHALL immediately force: Imem_Addr=RESET_PC, O_PC=0, O_PC4=0, O_Inst=NOP_INST, O_Valid=0, state FETCH, and the buffer empty.
REQ-031 Rst_n low mid-request SHALL abandon that request.
REQ-032 Imem_Req SHALL be 0 while Rst_n is low.
REQ-033 Imem_Req SHALL assert in the first cycle after Rst_n deasserts.

Configuration
REQ-034 Macro IF_FETCH_BUF_EN SHALL select the Stall behaviour; exactly this one feature is configurable.
REQ-035 With IF_FETCH_BUF_EN, Stall: a one-entry buffer SHALL capture one handshaked instruction (PC, Inst) during Stall.
REQ-036 With IF_FETCH_BUF_EN, Stall release: the buffered instruction SHALL drive O_* on the first cycle after release, with no bubble.
REQ-037 With IF_FETCH_BUF_EN, redirect: the buffer SHALL be cleared.
REQ-038 Without IF_FETCH_BUF_EN: a handshake completing during Stall SHALL be discarded and its address re-fetched after Stall drops.
REQ-039 Without IF_FETCH_BUF_EN: the FSM SHALL enter HOLD with Imem_Req=0 until Stall drops.

Structure
REQ-040 Shared package if_pkg SHALL hold the FSM state encoding, NOP_INST, and the PC width constant (32).
REQ-041 Sub-module if_fetch_buf SHALL implement the one-entry buffer; it is instantiated only under IF_FETCH_BUF_EN.

Verification
REQ-042 Reset release, Imem_Ready=1, Rdata=addr^32'hA5A5_0000: Imem_Addr 0,4,8; one cycle after each handshake O_PC=0/O_PC4=4, then O_PC=4/O_PC4=8, with O_Valid=1 throughout.
REQ-043 Imem_Ready low 3 cycles at 0x8: Imem_Addr holds 0x8 with Imem_Req=1 and O_Valid=0 for 3 cycles; then O_PC=0x8.
REQ-044 Branch_Taken, Branch_Target=0x40, while waiting at 0x10: data from 0x10 never reaches O_*; the next request is at 0x40.
REQ-045 Branch_Taken (0x80) and Jump (0x100) together: next Imem_Addr=0x80; O_Valid=0 for one cycle.
REQ-046 Stall 2 cycles at O_PC=0x4: O_* held; after release, O_PC=0x8 next cycle with IF_FETCH_BUF_EN, or one bubble then 0x8 without it.
REQ-047 Rst_n pulsed low during a wait at 0x20: outputs reset without waiting for Clk; the first request after release is at RESET_PC.
